// File: rtl/ser_tx_frame_pkg.sv
// Shared definitions for the framed serial transmitter: FSM state encodings and default geometry.
package ser_tx_frame_pkg;

  localparam int SER_TX_DEF_WIDTH        = 8;
  localparam int SER_TX_DEF_CLKS_PER_BIT = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } ser_tx_state_e;

endpackage

// File: rtl/ser_tx_bit_timer.sv
// Bit-time counter: runs 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module ser_tx_bit_timer
  import ser_tx_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = SER_TX_DEF_CLKS_PER_BIT
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            en_i,
  input  logic                            clr_i,
  output logic [$clog2(CLKS_PER_BIT):0]   cnt_o,
  output logic                            bit_end_o
);

  logic [$clog2(CLKS_PER_BIT):0] cnt_q;
  logic [$clog2(CLKS_PER_BIT):0] cnt_d;

  always_comb begin
    bit_end_o = en_i && (int'(cnt_q) == CLKS_PER_BIT - 1);
    cnt_d     = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = bit_end_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ser_tx_frame.sv
// Framed LSB-first serial transmitter (start, data, [parity], stop) with valid/ready input.
// Optional even-parity bit enabled by defining SER_TX_FRAME_PARITY_EN.
module ser_tx_frame
  import ser_tx_frame_pkg::*;
#(
  parameter int WIDTH        = SER_TX_DEF_WIDTH,
  parameter int CLKS_PER_BIT = SER_TX_DEF_CLKS_PER_BIT,
  parameter bit IDLE_LEVEL   = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sdo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int IW = $clog2(WIDTH) + 1;

  ser_tx_state_e    state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [IW-1:0]    bit_idx_q;
  logic             sdo_q;
  logic             busy_q;
  logic             done_q;
  logic             done_d;
`ifdef SER_TX_FRAME_PARITY_EN
  logic             parity_q;
`endif

  logic          accept;
  logic          last_data_bit;
  logic          entering_stop;
  logic          timer_en;
  logic          bit_end;
  logic [CW-1:0] cnt;

  assign in_ready      = (state_q == ST_IDLE);
  assign accept        = in_valid && in_ready;
  assign timer_en      = (state_q != ST_IDLE);
  assign shift_d       = shift_q >> 1;
  assign last_data_bit = (int'(bit_idx_q) == WIDTH - 1);

  ser_tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .en_i      (timer_en),
    .clr_i     (accept),
    .cnt_o     (cnt),
    .bit_end_o (bit_end)
  );

  // done is registered, so it is raised on the edge that enters the final stop-bit cycle.
  always_comb begin
`ifdef SER_TX_FRAME_PARITY_EN
    entering_stop = bit_end && (state_q == ST_PARITY);
`else
    entering_stop = bit_end && (state_q == ST_DATA) && last_data_bit;
`endif
    done_d = 1'b0;
    if (CLKS_PER_BIT == 1) begin
      done_d = entering_stop;
    end else if (state_q == ST_STOP && int'(cnt) == CLKS_PER_BIT - 2) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      sdo_q     <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SER_TX_FRAME_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      done_q <= done_d;
      case (state_q)
        ST_IDLE: begin
          sdo_q <= IDLE_LEVEL;
          if (accept) begin
            state_q   <= ST_START;
            shift_q   <= in_data;
            bit_idx_q <= '0;
            sdo_q     <= ~IDLE_LEVEL;
            busy_q    <= 1'b1;
`ifdef SER_TX_FRAME_PARITY_EN
            parity_q  <= ^in_data;
`endif
          end
        end
        ST_START: begin
          if (bit_end) begin
            state_q <= ST_DATA;
            sdo_q   <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (last_data_bit) begin
`ifdef SER_TX_FRAME_PARITY_EN
              state_q <= ST_PARITY;
              sdo_q   <= parity_q;
`else
              state_q <= ST_STOP;
              sdo_q   <= IDLE_LEVEL;
`endif
            end else begin
              shift_q   <= shift_d;
              sdo_q     <= shift_d[0];
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
`ifdef SER_TX_FRAME_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            state_q <= ST_STOP;
            sdo_q   <= IDLE_LEVEL;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          sdo_q   <= IDLE_LEVEL;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sdo  = sdo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
